// File: rtl/block_field_controller.sv
// Breakout block field owner: keeps the NUM_ROWS x BLOCKS_PER_ROW presence
// bits, shares the single row-access slot between painter prefetch, the
// level-init sweep and brick-hit requests, and tracks the blocks left.
module block_field_controller #(
   parameter int BLOCKS_PER_ROW = 13,
   parameter int NUM_ROWS       = 16,
   parameter int ROW_W          = 5,
   parameter int CNT_W          = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      new_frame,
   input  logic                      go_next_line,
   output logic [BLOCKS_PER_ROW-1:0] block_line_state,
   input  logic                      hit_req,
   input  logic [3:0]                hit_row,
   input  logic [3:0]                hit_col,
   output logic                      hit_ack,
   output logic                      hit_was_present,
   input  logic                      level_init,
   output logic                      init_busy,
   output logic [CNT_W-1:0]          blocks_left,
   output logic                      level_clear
);

   localparam int                      IDX_W      = $clog2(NUM_ROWS);
   localparam logic [CNT_W-1:0]        FULL_COUNT = CNT_W'(NUM_ROWS * BLOCKS_PER_ROW);
   localparam logic [ROW_W-1:0]        ROW_END    = ROW_W'(NUM_ROWS);
   localparam logic [ROW_W-1:0]        LAST_ROW   = ROW_W'(NUM_ROWS - 1);
   localparam logic [BLOCKS_PER_ROW-1:0] BIT0     = BLOCKS_PER_ROW'(1);

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t                    state_q, state_d;
   logic [ROW_W-1:0]          sweep_q, sweep_d;
   logic [ROW_W-1:0]          fetch_row_q, fetch_row_d;
   logic                      fetch_pend_q, fetch_pend_d;
   logic                      hit_pend_q, hit_pend_d;
   logic                      hit_armed_q, hit_armed_d;
   logic [BLOCKS_PER_ROW-1:0] line_q, line_d;
   logic                      hit_ack_q, hit_ack_d;
   logic                      hit_present_q, hit_present_d;
   logic                      init_busy_q, init_busy_d;
   logic [CNT_W-1:0]          blocks_left_q, blocks_left_d;
   logic                      level_clear_q, level_clear_d;

   logic [BLOCKS_PER_ROW-1:0] field_q [NUM_ROWS];
   logic                      field_we;
   logic [IDX_W-1:0]          field_wa;
   logic [BLOCKS_PER_ROW-1:0] field_wd;

   logic                      hit_in_range;
   logic [BLOCKS_PER_ROW-1:0] hit_row_data;
   logic                      hit_old_bit;

   // Decode the hit address and look up the targeted block's current bit.
   always_comb begin
      hit_in_range = (32'(hit_row) < NUM_ROWS) && (32'(hit_col) < BLOCKS_PER_ROW);
      hit_row_data = field_q[IDX_W'(hit_row)];
      hit_old_bit  = hit_in_range && hit_row_data[hit_col];
   end

   // Next-state logic: the fetch slot always wins, then the init sweep, then hits.
   always_comb begin
      state_d       = state_q;
      sweep_d       = sweep_q;
      fetch_row_d   = fetch_row_q;
      fetch_pend_d  = fetch_pend_q;
      hit_pend_d    = hit_pend_q;
      hit_armed_d   = hit_armed_q;
      line_d        = line_q;
      hit_ack_d     = 1'b0;
      hit_present_d = 1'b0;
      init_busy_d   = init_busy_q;
      blocks_left_d = blocks_left_q;
      field_we      = 1'b0;
      field_wa      = '0;
      field_wd      = '0;

      if (fetch_pend_q) begin
         line_d       = (fetch_row_q < ROW_END) ? field_q[IDX_W'(fetch_row_q)] : '0;
         fetch_pend_d = 1'b0;
      end
      if (new_frame) begin
         fetch_row_d  = '0;
         fetch_pend_d = 1'b1;
      end else if (go_next_line) begin
         fetch_row_d  = (fetch_row_q < ROW_END) ? fetch_row_q + ROW_W'(1) : ROW_END;
         fetch_pend_d = 1'b1;
      end

      if (hit_req && hit_armed_q) begin
         hit_pend_d  = 1'b1;
         hit_armed_d = 1'b0;
      end else if (!hit_req) begin
         hit_armed_d = 1'b1;
      end

      case (state_q)
         ST_INIT: begin
            if (level_init) begin
               sweep_d = '0;
            end else if (!fetch_pend_q) begin
               field_we = 1'b1;
               field_wa = IDX_W'(sweep_q);
               field_wd = '1;
               if (sweep_q == LAST_ROW) begin
                  state_d       = ST_IDLE;
                  sweep_d       = '0;
                  init_busy_d   = 1'b0;
                  blocks_left_d = FULL_COUNT;
               end else begin
                  sweep_d = sweep_q + ROW_W'(1);
               end
            end
         end
         default: begin
            if (level_init) begin
               state_d     = ST_INIT;
               sweep_d     = '0;
               init_busy_d = 1'b1;
            end else if (hit_pend_q && !fetch_pend_q) begin
               hit_pend_d    = 1'b0;
               hit_ack_d     = 1'b1;
               hit_present_d = hit_old_bit;
               if (hit_old_bit) begin
                  field_we      = 1'b1;
                  field_wa      = IDX_W'(hit_row);
                  field_wd      = hit_row_data & ~(BIT0 << hit_col);
                  blocks_left_d = blocks_left_q - CNT_W'(1);
               end
            end
         end
      endcase

      level_clear_d = (blocks_left_d == '0) && !init_busy_d;
   end

   // Control and output registers; reset aborts any sweep or pending hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_INIT;
         sweep_q       <= '0;
         fetch_row_q   <= '0;
         fetch_pend_q  <= 1'b0;
         hit_pend_q    <= 1'b0;
         hit_armed_q   <= 1'b1;
         line_q        <= '0;
         hit_ack_q     <= 1'b0;
         hit_present_q <= 1'b0;
         init_busy_q   <= 1'b1;
         blocks_left_q <= '0;
         level_clear_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sweep_q       <= sweep_d;
         fetch_row_q   <= fetch_row_d;
         fetch_pend_q  <= fetch_pend_d;
         hit_pend_q    <= hit_pend_d;
         hit_armed_q   <= hit_armed_d;
         line_q        <= line_d;
         hit_ack_q     <= hit_ack_d;
         hit_present_q <= hit_present_d;
         init_busy_q   <= init_busy_d;
         blocks_left_q <= blocks_left_d;
         level_clear_q <= level_clear_d;
      end
   end

   // Field storage has no reset; the init sweep rewrites every row.
   always_ff @(posedge clk) begin
      if (field_we && !rst) begin
         field_q[field_wa] <= field_wd;
      end
   end

   assign block_line_state = line_q;
   assign hit_ack          = hit_ack_q;
   assign hit_was_present  = hit_present_q;
   assign init_busy        = init_busy_q;
   assign blocks_left      = blocks_left_q;
   assign level_clear      = level_clear_q;

endmodule

// File: tb/tb_block_field_controller.sv
// Self-checking bench for block_field_controller: a fetch table plus
// hand-written hit, init and reset sequences, checked against a field model.
module tb_block_field_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        new_frame;
   logic        go_next_line;
   logic [12:0] block_line_state;
   logic        hit_req;
   logic [3:0]  hit_row;
   logic [3:0]  hit_col;
   logic        hit_ack;
   logic        hit_was_present;
   logic        level_init;
   logic        init_busy;
   logic [7:0]  blocks_left;
   logic        level_clear;

   int check_count = 0;
   int fail_count  = 0;

   bit [12:0]   model_field [16];
   int          model_left;
   logic [12:0] line_q[$];
   bit          hit_q[$];

   typedef struct {
      bit          nf;
      bit          gnl;
      logic [12:0] exp_line;
   } fetch_vec_t;

   fetch_vec_t fetch_tab [17];

   block_field_controller dut (
      .clk              (clk),
      .rst              (rst),
      .new_frame        (new_frame),
      .go_next_line     (go_next_line),
      .block_line_state (block_line_state),
      .hit_req          (hit_req),
      .hit_row          (hit_row),
      .hit_col          (hit_col),
      .hit_ack          (hit_ack),
      .hit_was_present  (hit_was_present),
      .level_init       (level_init),
      .init_busy        (init_busy),
      .blocks_left      (blocks_left),
      .level_clear      (level_clear)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit nf, input bit gnl, input bit li);
      new_frame    = nf;
      go_next_line = gnl;
      level_init   = li;
      tick();
      new_frame    = 1'b0;
      go_next_line = 1'b0;
      level_init   = 1'b0;
   endtask

   function automatic logic [12:0] model_row(input int r);
      return (r < 16) ? model_field[r] : 13'h0000;
   endfunction

   task automatic fillModel();
      for (int r = 0; r < 16; r++) model_field[r] = 13'h1FFF;
      model_left = 208;
   endtask

   // One fetch event whose result is checked one clock after the event
   task automatic doFetch(input bit nf, input bit gnl, input logic [12:0] exp_line, input string name);
      line_q.push_back(exp_line);
      applyStimulus(nf, gnl, 1'b0);
      tick();
      checkOutput(name, block_line_state, line_q.pop_front());
   endtask

   task automatic fetchRow(input int r);
      doFetch(1'b1, 1'b0, model_row(0), "fetch_row0");
      for (int i = 1; i <= r; i++) doFetch(1'b0, 1'b1, model_row(i), "fetch_rowN");
   endtask

   // Full hit handshake; hold keeps hit_req high for extra cycles after ack
   task automatic doHit(input int r, input int c, input int exp_lat, input int hold);
      int  cnt;
      bit  acked;
      bit  exp_present;
      exp_present = (r < 16 && c < 13) ? model_field[r][c] : 1'b0;
      if (exp_present) begin
         model_field[r][c] = 1'b0;
         model_left--;
      end
      hit_q.push_back(exp_present);
      hit_row = 4'(r);
      hit_col = 4'(c);
      hit_req = 1'b1;
      cnt     = 0;
      acked   = 1'b0;
      while (!acked && cnt < 20) begin
         tick();
         cnt++;
         acked = hit_ack;
      end
      if (!acked) begin
         checkOutput("hit_ack_timeout", 32'd0, 32'd1);
         void'(hit_q.pop_front());
      end else begin
         checkOutput("hit_present", 32'(hit_was_present), 32'(hit_q.pop_front()));
         if (exp_lat > 0) checkOutput("hit_latency", cnt, exp_lat);
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         checkOutput("hit_no_regrant", 32'(hit_ack), 32'd0);
      end
      hit_req = 1'b0;
      tick();
      checkOutput("hit_ack_pulse", 32'(hit_ack), 32'd0);
      checkOutput("blocks_left", 32'(blocks_left), model_left);
   endtask

   initial begin
      int  cnt;
      bit  bad;
      rst          = 1'b1;
      new_frame    = 1'b0;
      go_next_line = 1'b0;
      hit_req      = 1'b0;
      hit_row      = '0;
      hit_col      = '0;
      level_init   = 1'b0;

      fetch_tab[0] = '{nf: 1'b1, gnl: 1'b0, exp_line: 13'h1FFF};
      for (int i = 1; i < 16; i++) fetch_tab[i] = '{nf: 1'b0, gnl: 1'b1, exp_line: 13'h1FFF};
      fetch_tab[16] = '{nf: 1'b0, gnl: 1'b1, exp_line: 13'h0000};

      // Reset state
      tick();
      tick();
      checkOutput("rst_init_busy", 32'(init_busy), 32'd1);
      checkOutput("rst_blocks_left", 32'(blocks_left), 32'd0);
      checkOutput("rst_level_clear", 32'(level_clear), 32'd0);
      checkOutput("rst_hit_ack", 32'(hit_ack), 32'd0);
      checkOutput("rst_line_state", 32'(block_line_state), 32'd0);
      rst = 1'b0;

      // Initial sweep takes 16 writes
      for (int i = 0; i < 15; i++) tick();
      checkOutput("init_busy_during_sweep", 32'(init_busy), 32'd1);
      tick();
      checkOutput("init_busy_done", 32'(init_busy), 32'd0);
      checkOutput("init_blocks_left", 32'(blocks_left), 32'd208);
      checkOutput("init_level_clear", 32'(level_clear), 32'd0);
      fillModel();

      // Table-driven fetch of every row plus the saturated row 16
      foreach (fetch_tab[i]) doFetch(fetch_tab[i].nf, fetch_tab[i].gnl, fetch_tab[i].exp_line, "fetch_table");

      // Hit row 2 col 5 twice, then see it in a fetch
      doHit(2, 5, 2, 0);
      checkOutput("hit1_blocks_left", 32'(blocks_left), 32'd207);
      doHit(2, 5, 2, 0);
      checkOutput("hit2_blocks_left", 32'(blocks_left), 32'd207);
      fetchRow(2);
      checkOutput("fetch_row2_cleared", 32'(block_line_state), 32'h1FDF);

      // Hit raised together with go_next_line: fetch first, ack one cycle later
      fetchRow(0);
      line_q.push_back(model_row(1));
      hit_q.push_back(model_field[3][0]);
      model_field[3][0] = 1'b0;
      model_left--;
      hit_row      = 4'd3;
      hit_col      = 4'd0;
      hit_req      = 1'b1;
      go_next_line = 1'b1;
      tick();
      go_next_line = 1'b0;
      tick();
      checkOutput("contend_fetch_line", 32'(block_line_state), 32'(line_q.pop_front()));
      checkOutput("contend_ack_deferred", 32'(hit_ack), 32'd0);
      tick();
      checkOutput("contend_ack", 32'(hit_ack), 32'd1);
      checkOutput("contend_present", 32'(hit_was_present), 32'(hit_q.pop_front()));
      hit_req = 1'b0;
      tick();
      checkOutput("contend_blocks_left", 32'(blocks_left), model_left);

      // Out-of-range column, last valid block with held request, then clear all
      doHit(0, 13, 2, 0);
      doHit(15, 12, 2, 3);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 13; c++) doHit(r, c, 0, 0);
      checkOutput("all_cleared_left", 32'(blocks_left), 32'd0);
      checkOutput("all_cleared_level_clear", 32'(level_clear), 32'd1);

      // level_init refills the field
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("reinit_busy", 32'(init_busy), 32'd1);
      checkOutput("reinit_level_clear", 32'(level_clear), 32'd0);
      cnt = 0;
      while (init_busy && cnt < 40) begin
         tick();
         cnt++;
      end
      checkOutput("reinit_sweep_len", cnt, 32'd16);
      checkOutput("reinit_blocks_left", 32'(blocks_left), 32'd208);
      checkOutput("reinit_level_clear_low", 32'(level_clear), 32'd0);
      fillModel();
      fetchRow(2);

      // Reset at sweep row 7 with a hit waiting: no ack, sweep restarts
      doHit(4, 4, 2, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         bad |= hit_ack;
      end
      hit_row = 4'd1;
      hit_col = 4'd1;
      hit_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         bad |= hit_ack;
      end
      checkOutput("init_hit_waits", 32'(bad), 32'd0);
      rst     = 1'b1;
      hit_req = 1'b0;
      tick();
      rst = 1'b0;
      checkOutput("midrst_hit_ack", 32'(hit_ack), 32'd0);
      checkOutput("midrst_init_busy", 32'(init_busy), 32'd1);
      checkOutput("midrst_blocks_left", 32'(blocks_left), 32'd0);
      cnt = 0;
      bad = 1'b0;
      while (init_busy && cnt < 40) begin
         bad |= hit_ack || (blocks_left != 8'd0);
         tick();
         cnt++;
      end
      checkOutput("midrst_sweep_len", cnt, 32'd16);
      checkOutput("midrst_quiet_during_sweep", 32'(bad), 32'd0);
      checkOutput("midrst_blocks_left_done", 32'(blocks_left), 32'd208);
      fillModel();
      fetchRow(4);

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
